// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Sums LEN consecutive PW-bit multiplier products into one AW-bit
//               frame result with valid/ready on both sides and a per-frame
//               overflow flag. Define PACC_SATURATE_EN to clamp on overflow
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator #(
  parameter int PW  = 8,   // product width
  parameter int AW  = 12,  // accumulator width, AW >= PW
  parameter int LEN = 4,   // products per frame, LEN >= 1
  localparam int CW = $clog2(LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [PW-1:0] prod_in,
  input  logic          prod_valid,
  output logic          prod_ready,
  output logic [AW-1:0] sum_out,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic          sum_ovf,
  output logic [CW-1:0] beat_cnt
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(LEN - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t        state_q,      state_d;
  logic [AW-1:0] acc_q,        acc_d;
  logic [CW-1:0] beat_cnt_q,   beat_cnt_d;
  logic          ovf_sticky_q, ovf_sticky_d;
  logic [AW-1:0] sum_out_q,    sum_out_d;
  logic          sum_valid_q,  sum_valid_d;
  logic          sum_ovf_q,    sum_ovf_d;

  logic [AW:0]   sum_w;
  logic          carry_w;
  logic [AW-1:0] acc_next_w;

  always_comb begin
    sum_w   = {1'b0, acc_q} + (AW+1)'(prod_in);
    carry_w = sum_w[AW];
`ifdef PACC_SATURATE_EN
    // Once clamped, acc is all-ones, so any later non-zero add carries again
    // and a zero add leaves it unchanged: the clamp persists for the frame.
    acc_next_w = carry_w ? {AW{1'b1}} : sum_w[AW-1:0];
`else
    acc_next_w = sum_w[AW-1:0];
`endif
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    beat_cnt_d   = beat_cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    sum_out_d    = sum_out_q;
    sum_valid_d  = sum_valid_q;
    sum_ovf_d    = sum_ovf_q;

    if (clear) begin
      // Frame abort masks any handshake; sum_out keeps its last value.
      state_d      = ST_ACCUM;
      acc_d        = '0;
      beat_cnt_d   = '0;
      ovf_sticky_d = 1'b0;
      sum_valid_d  = 1'b0;
      sum_ovf_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (prod_valid) begin
            if (beat_cnt_q == LAST_BEAT) begin
              sum_out_d    = acc_next_w;
              sum_ovf_d    = ovf_sticky_q | carry_w;
              sum_valid_d  = 1'b1;
              acc_d        = '0;
              beat_cnt_d   = '0;
              ovf_sticky_d = 1'b0;
              state_d      = ST_HOLD;
            end else begin
              acc_d        = acc_next_w;
              ovf_sticky_d = ovf_sticky_q | carry_w;
              beat_cnt_d   = beat_cnt_q + CW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (sum_ready) begin
            sum_valid_d = 1'b0;
            state_d     = ST_ACCUM;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ACCUM;
      acc_q        <= '0;
      beat_cnt_q   <= '0;
      ovf_sticky_q <= 1'b0;
      sum_out_q    <= '0;
      sum_valid_q  <= 1'b0;
      sum_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      beat_cnt_q   <= beat_cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
      sum_out_q    <= sum_out_d;
      sum_valid_q  <= sum_valid_d;
      sum_ovf_q    <= sum_ovf_d;
    end
  end

  assign prod_ready = (state_q == ST_ACCUM);
  assign sum_out    = sum_out_q;
  assign sum_valid  = sum_valid_q;
  assign sum_ovf    = sum_ovf_q;
  assign beat_cnt   = beat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_accumulator
// Description : Self-checking bench for product_accumulator (three instances:
//               default, AW=9 overflow case, LEN=1 case).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] prod_in;
  logic       clear0, clear1, clear2;
  logic       v0, v1, v2, r0, r1, r2;
  logic       pr0, pr1, pr2, sv0, sv1, sv2, ovf0, ovf1, ovf2;
  logic [11:0] so0;
  logic [8:0]  so1;
  logic [7:0]  so2;
  logic [2:0]  bc0, bc1;
  logic [0:0]  bc2;

  product_accumulator #(.PW(8), .AW(12), .LEN(4)) d0 (
    .clk(clk), .reset(reset), .clear(clear0), .prod_in(prod_in),
    .prod_valid(v0), .prod_ready(pr0), .sum_out(so0), .sum_valid(sv0),
    .sum_ready(r0), .sum_ovf(ovf0), .beat_cnt(bc0));

  product_accumulator #(.PW(8), .AW(9), .LEN(4)) d1 (
    .clk(clk), .reset(reset), .clear(clear1), .prod_in(prod_in),
    .prod_valid(v1), .prod_ready(pr1), .sum_out(so1), .sum_valid(sv1),
    .sum_ready(r1), .sum_ovf(ovf1), .beat_cnt(bc1));

  product_accumulator #(.PW(8), .AW(8), .LEN(1)) d2 (
    .clk(clk), .reset(reset), .clear(clear2), .prod_in(prod_in),
    .prod_valid(v2), .prod_ready(pr2), .sum_out(so2), .sum_valid(sv2),
    .sum_ready(r2), .sum_ovf(ovf2), .beat_cnt(bc2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d0(input string tag, input int beat, input logic sv,
                        input logic [11:0] sum, input logic ovf, input logic pr);
    chk({tag, " beat"},  32'(bc0),  32'(beat));
    chk({tag, " valid"}, 32'(sv0),  32'(sv));
    chk({tag, " sum"},   32'(so0),  32'(sum));
    chk({tag, " ovf"},   32'(ovf0), 32'(ovf));
    chk({tag, " ready"}, 32'(pr0),  32'(pr));
  endtask

  typedef struct {
    logic        clr;
    logic        v;
    logic [7:0]  p;
    logic        rdy;
    int          beat;
    logic        sv;
    logic [11:0] sum;
    logic        pr;
  } vec_t;

  vec_t tbl[$];

  // Saturation-aware expected frame result for the AW=9 instance.
  function automatic logic [8:0] frame_sum9(input int total);
`ifdef PACC_SATURATE_EN
    return (total >= 512) ? 9'h1FF : 9'(total);
`else
    return 9'(total % 512);
`endif
  endfunction

  initial begin
    // basic frame, backpressure, gaps, clear
    tbl.push_back('{0, 1, 8'h0F, 0, 1, 0, 12'h000, 1});
    tbl.push_back('{0, 1, 8'h10, 0, 2, 0, 12'h000, 1});
    tbl.push_back('{0, 1, 8'hFF, 0, 3, 0, 12'h000, 1});
    tbl.push_back('{0, 1, 8'h01, 0, 0, 1, 12'h11F, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{0, 1, 8'h20, 0, 0, 1, 12'h11F, 0});
    tbl.push_back('{0, 1, 8'h20, 1, 0, 0, 12'h11F, 1});
    tbl.push_back('{0, 1, 8'h20, 0, 1, 0, 12'h11F, 1});
    tbl.push_back('{1, 0, 8'h00, 0, 0, 0, 12'h11F, 1});
    tbl.push_back('{0, 1, 8'h01, 0, 1, 0, 12'h11F, 1});
    tbl.push_back('{0, 0, 8'hAA, 0, 1, 0, 12'h11F, 1});
    tbl.push_back('{0, 1, 8'h02, 0, 2, 0, 12'h11F, 1});
    tbl.push_back('{0, 0, 8'hAA, 0, 2, 0, 12'h11F, 1});
    tbl.push_back('{0, 1, 8'h03, 0, 3, 0, 12'h11F, 1});
    tbl.push_back('{0, 0, 8'hAA, 0, 3, 0, 12'h11F, 1});
    tbl.push_back('{0, 1, 8'h04, 0, 0, 1, 12'h00A, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 12'h00A, 1});
    tbl.push_back('{0, 1, 8'h05, 0, 1, 0, 12'h00A, 1});
    tbl.push_back('{0, 1, 8'h06, 0, 2, 0, 12'h00A, 1});
    tbl.push_back('{1, 1, 8'h07, 0, 0, 0, 12'h00A, 1});
    tbl.push_back('{0, 1, 8'h01, 0, 1, 0, 12'h00A, 1});
    tbl.push_back('{0, 1, 8'h01, 0, 2, 0, 12'h00A, 1});
    tbl.push_back('{0, 1, 8'h01, 0, 3, 0, 12'h00A, 1});
    tbl.push_back('{0, 1, 8'h01, 0, 0, 1, 12'h004, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 12'h004, 1});

    reset = 1'b0; prod_in = '0;
    clear0 = 0; clear1 = 0; clear2 = 0;
    v0 = 0; v1 = 0; v2 = 0; r0 = 0; r1 = 0; r2 = 0;
    step; step;
    chk_d0("reset", 0, 0, 12'h000, 0, 1);
    reset = 1'b1;
    step;

    foreach (tbl[i]) begin
      clear0 = tbl[i].clr; v0 = tbl[i].v; prod_in = tbl[i].p; r0 = tbl[i].rdy;
      step;
      chk_d0($sformatf("row%0d", i), tbl[i].beat, tbl[i].sv, tbl[i].sum, 1'b0, tbl[i].pr);
    end
    clear0 = 0; v0 = 0; r0 = 0;

    // mid-frame reset discards the partial frame
    v0 = 1; prod_in = 8'h09;
    step; step;
    chk("pre-reset beat", 32'(bc0), 32'd2);
    v0 = 0; reset = 1'b0;
    #2;
    chk_d0("async reset", 0, 0, 12'h000, 0, 1);
    step;
    chk_d0("held reset", 0, 0, 12'h000, 0, 1);
    reset = 1'b1;
    step;
    chk("post-reset valid", 32'(sv0), 32'd0);
    v0 = 1; prod_in = 8'h02;
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("post-reset frame valid%0d", i), 32'(sv0), 32'd0);
    end
    step;
    chk_d0("post-reset frame", 0, 1, 12'h008, 0, 0);
    v0 = 0; r0 = 1;
    step;
    chk("post-reset consume", 32'(sv0), 32'd0);
    r0 = 0;

    // overflow on AW=9
    v1 = 1; prod_in = 8'hFF;
    for (int i = 0; i < 4; i++) step;
    chk("ovf9 valid", 32'(sv1), 32'd1);
    chk("ovf9 sum",   32'(so1), 32'(frame_sum9(4 * 255)));
    chk("ovf9 flag",  32'(ovf1), 32'd1);
    v1 = 0; r1 = 1;
    step;
    chk("ovf9 consume", 32'(sv1), 32'd0);
    r1 = 0; v1 = 1; prod_in = 8'h10;
    for (int i = 0; i < 4; i++) step;
    chk("nov9 sum",  32'(so1), 32'h040);
    chk("nov9 flag", 32'(ovf1), 32'd0);
    v1 = 0; r1 = 1;
    step;
    r1 = 0;

    // LEN==1: each product is its own frame
    v2 = 1; prod_in = 8'h33;
    step;
    chk("len1 valid", 32'(sv2), 32'd1);
    chk("len1 sum",   32'(so2), 32'h33);
    chk("len1 beat",  32'(bc2), 32'd0);
    chk("len1 ready", 32'(pr2), 32'd0);
    prod_in = 8'h44;
    step;
    chk("len1 hold sum", 32'(so2), 32'h33);
    r2 = 1;
    step;
    chk("len1 consume", 32'(sv2), 32'd0);
    chk("len1 ready2",  32'(pr2), 32'd1);
    r2 = 0;
    step;
    chk("len1 second sum", 32'(so2), 32'h44);
    chk("len1 ovf",        32'(ovf2), 32'd0);
    v2 = 0; r2 = 1;
    step;
    r2 = 0;

    // randomized traffic on the AW=9 instance against a frame-level model
    begin
      bit         hold = 0;
      int         cnt = 0;
      int         total = 0;
      logic       exp_sv = 0;
      logic       exp_ovf = 0;
      logic [8:0] exp_sum = 9'h040;
      for (int n = 0; n < 1500; n++) begin
        clear1  = ($urandom_range(0, 15) == 0);
        v1      = $urandom_range(0, 1);
        r1      = $urandom_range(0, 1);
        prod_in = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        if (clear1) begin
          hold = 0; cnt = 0; total = 0; exp_sv = 0; exp_ovf = 0;
        end else if (!hold && v1) begin
          total += prod_in;
          cnt++;
          if (cnt == 4) begin
            exp_sum = frame_sum9(total);
            exp_ovf = (total >= 512);
            exp_sv  = 1;
            hold = 1; cnt = 0; total = 0;
          end
        end else if (hold && r1) begin
          hold = 0; exp_sv = 0;
        end
        step;
        chk($sformatf("rnd%0d beat", n),  32'(bc1),  32'(cnt));
        chk($sformatf("rnd%0d valid", n), 32'(sv1),  32'(exp_sv));
        chk($sformatf("rnd%0d sum", n),   32'(so1),  32'(exp_sum));
        chk($sformatf("rnd%0d ovf", n),   32'(ovf1), 32'(exp_ovf));
        chk($sformatf("rnd%0d ready", n), 32'(pr1),  32'(!hold));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
